// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared FSM states, region codes and peripheral map for the memory/IO bus unit
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_LED_SW,
    RGN_CNT,
    RGN_UNMAPPED
  } region_t;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hF000_0000;
  localparam logic [31:0] LED_SW_OFS      = 32'h0000_0000;
  localparam logic [31:0] CNT_OFS         = 32'h0000_0004;

endpackage

// File: rtl/mio_bus_if.sv
// rtl/mio_bus_if.sv - CPU-side request/response bundle between the controller and the bus unit
interface mio_bus_if;

  logic        mem_r;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] cpu_data2bus;
  logic [31:0] cpu_data4bus;
  logic        MIO_ready;
  logic        bus_err;

  modport master (
    output mem_r,
    output mem_w,
    output addr_bus,
    output cpu_data2bus,
    input  cpu_data4bus,
    input  MIO_ready,
    input  bus_err
  );

  modport slave (
    input  mem_r,
    input  mem_w,
    input  addr_bus,
    input  cpu_data2bus,
    output cpu_data4bus,
    output MIO_ready,
    output bus_err
  );

endinterface

// File: rtl/mio_decode.sv
// rtl/mio_decode.sv - combinational byte address to region decoder (word granularity)
module mio_decode
  import mio_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic [31:0] addr,
  output region_t     region
);

  logic [31:0] word_addr;

  always_comb begin
    // Byte-lane bits are ignored: every access is a full word.
    word_addr = addr & ~32'h0000_0003;
    if (addr[31:RAM_AW+2] == '0) begin
      region = RGN_RAM;
    end else if (word_addr == IO_BASE + LED_SW_OFS) begin
      region = RGN_LED_SW;
    end else if (word_addr == IO_BASE + CNT_OFS) begin
      region = RGN_CNT;
    end else begin
      region = RGN_UNMAPPED;
    end
  end

endmodule

// File: rtl/mio_bus.sv
// rtl/mio_bus.sv - memory/IO bus unit: RAM sequencing, LED/switch and counter peripherals, ready pulse
module mio_bus
  import mio_pkg::*;
#(
  parameter int          RAM_AW      = 10,
  parameter int          RAM_LATENCY = 2,
  parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_if.slave          bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
);

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  state_t      state;
  state_t      state_nxt;
  region_t     region;
  logic        req;
  logic        req_wr;
  logic        take_req;
  logic        ram_done;
  logic        lat_wr;
  logic [2:0]  wait_cnt;
  logic [31:0] counter;

  mio_decode #(
    .RAM_AW  (RAM_AW),
    .IO_BASE (IO_BASE)
  ) u_decode (
    .addr   (bus.addr_bus),
    .region (region)
  );

  // A simultaneous read and write strobe is serviced as a write.
  assign req    = bus.mem_r | bus.mem_w;
  assign req_wr = bus.mem_w;

  assign bus.MIO_ready = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    ram_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          take_req  = 1'b1;
          state_nxt = (region == RGN_RAM) ? RAM_WAIT : DONE;
        end
      end
      RAM_WAIT: begin
        if (wait_cnt == LAT) begin
          ram_done  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RAM side: address/data are latched on acceptance, write strobe lasts one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      lat_wr   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      ram_we <= 1'b0;
      if (take_req) begin
        lat_wr <= req_wr;
        if (region == RGN_RAM) begin
          ram_addr <= bus.addr_bus[RAM_AW+1:2];
          ram_din  <= bus.cpu_data2bus;
          ram_we   <= req_wr;
          wait_cnt <= 3'd1;
        end
      end else if (ram_done) begin
        wait_cnt <= '0;
      end else if (state == RAM_WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end

  // Read data register holds the last completed read; writes leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_data4bus <= '0;
    end else if (ram_done && !lat_wr) begin
      bus.cpu_data4bus <= ram_dout;
    end else if (take_req && !req_wr) begin
      unique case (region)
        RGN_LED_SW:   bus.cpu_data4bus <= {16'h0000, sw_in};
        RGN_CNT:      bus.cpu_data4bus <= counter;
        RGN_UNMAPPED: bus.cpu_data4bus <= '0;
        default:      bus.cpu_data4bus <= bus.cpu_data4bus;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else if (take_req && req_wr && region == RGN_LED_SW) begin
      led_out <= bus.cpu_data2bus[15:0];
    end
  end

  // A counter write replaces that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (take_req && req_wr && region == RGN_CNT) begin
      counter <= bus.cpu_data2bus;
    end else begin
      counter <= counter + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_err <= 1'b0;
    end else if (take_req && ((bus.mem_r && bus.mem_w) || region == RGN_UNMAPPED)) begin
      bus.bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mio_bus.sv
// tb/tb_mio_bus.sv - self-checking bench for mio_bus: vector table, corner sequences, randomized traffic
module tb_mio_bus;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  mio_bus_if bus ();

  mio_bus #(
    .RAM_AW      (10),
    .RAM_LATENCY (L),
    .IO_BASE     (32'hF000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .sw_in    (sw_in),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  // Block RAM device: one output register, so data is ready L-1 edges after the address.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          we_total = 0;
  logic [9:0]  we_addr;
  always @(negedge clk) begin
    if (ram_we) begin
      we_total = we_total + 1;
      we_addr  = ram_addr;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  logic [31:0] m_rd;
  logic        m_err;
  logic [15:0] m_led;
  int          m_lat;
  int          m_we;
  logic [31:0] cnt_base;
  int unsigned cnt_cyc;
  logic [31:0] last_a;

  // Observed results of the last transaction
  int          act_lat;
  int          act_we;
  logic [31:0] act_rd;
  logic        act_err;
  logic [15:0] act_led;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] sw;
    logic [31:0] rd;
    int          lat;
    logic        err;
    logic [15:0] led;
    int          we;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (a[31:12] == 20'h0) return 0;
    if (wa == 32'hF000_0000) return 1;
    if (wa == 32'hF000_0004) return 2;
    return 3;
  endfunction

  task automatic apply(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [15:0] sw);
    int          rg;
    int          we0;
    int unsigned rc;
    @(negedge clk);
    sw_in            = sw;
    bus.mem_r        = r;
    bus.mem_w        = w;
    bus.addr_bus     = a;
    bus.cpu_data2bus = d;
    we0     = we_total;
    act_lat = 0;
    rc      = 0;
    do begin
      @(posedge clk);
      act_lat++;
      @(negedge clk);
      if (act_lat == 1) begin
        rc        = cyc;
        bus.mem_r = 1'b0;
        bus.mem_w = 1'b0;
      end
    end while (!bus.MIO_ready && act_lat < 16);
    act_rd  = bus.cpu_data4bus;
    act_err = bus.bus_err;
    act_led = led_out;
    act_we  = we_total - we0;
    last_a  = a;

    rg    = region(a);
    m_lat = (rg == 0) ? 1 + L : 1;
    m_we  = 0;
    if ((r && w) || rg == 3) m_err = 1'b1;
    if (w) begin
      case (rg)
        0: begin ref_mem[a[11:2]] = d; m_we = 1; end
        1: m_led = d[15:0];
        2: begin cnt_base = d; cnt_cyc = rc; end
        default: ;
      endcase
    end else begin
      case (rg)
        0: m_rd = ref_mem[a[11:2]];
        1: m_rd = {16'h0000, sw};
        2: m_rd = cnt_base + (rc - 1 - cnt_cyc);
        default: m_rd = 32'h0;
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_lat"}, act_lat, m_lat);
    chk({tag, "_rd"}, act_rd, m_rd);
    chk({tag, "_err"}, act_err, m_err);
    chk({tag, "_led"}, act_led, m_led);
    chk({tag, "_we"}, act_we, m_we);
    if (m_we == 1) chk({tag, "_waddr"}, we_addr, last_a[11:2]);
  endtask

  task automatic model_reset();
    m_rd     = '0;
    m_err    = 1'b0;
    m_led    = '0;
    cnt_base = '0;
    cnt_cyc  = cyc;
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] ra;
    logic [31:0] rd_v;
    int          seen;
    int          op;
    int          sel;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    bus.mem_r        = 1'b0;
    bus.mem_w        = 1'b0;
    bus.addr_bus     = '0;
    bus.cpu_data2bus = '0;
    sw_in            = '0;
    reset            = 1'b1;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 3, 1'b0, 16'h0000, 1};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 32'hDEAD_BEEF, 3, 1'b0, 16'h0000, 0};
    tbl[2]  = '{1'b0, 1'b1, 32'hF000_0000, 32'h0001_A5A5, 16'h0000, 32'hDEAD_BEEF, 1, 1'b0, 16'hA5A5, 0};
    tbl[3]  = '{1'b1, 1'b0, 32'hF000_0000, 32'h0000_0000, 16'h3C3C, 32'h0000_3C3C, 1, 1'b0, 16'hA5A5, 0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 16'h0000, 32'h0000_3C3C, 3, 1'b0, 16'hA5A5, 1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0FFE, 32'h0000_0000, 16'h0000, 32'h1234_5678, 3, 1'b0, 16'hA5A5, 0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 1'b1, 16'hA5A5, 0};
    tbl[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 16'h0000, 32'h0000_0000, 3, 1'b1, 16'hA5A5, 1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 16'h0000, 32'hCAFE_F00D, 3, 1'b1, 16'hA5A5, 0};
    tbl[9]  = '{1'b1, 1'b0, 32'hF000_0002, 32'h0000_0000, 16'h1234, 32'h0000_1234, 1, 1'b1, 16'hA5A5, 0};
    tbl[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1, 1'b1, 16'hA5A5, 0};
    tbl[11] = '{1'b0, 1'b1, 32'hF000_000C, 32'h0000_0055, 16'h0000, 32'h0000_0000, 1, 1'b1, 16'hA5A5, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.MIO_ready, 1'b0);
    chk("rst_rd", bus.cpu_data4bus, 32'h0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_addr", ram_addr, 10'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_led", led_out, 16'h0);
    chk("rst_err", bus.bus_err, 1'b0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sw);
      chk($sformatf("vec%0d_lat", i), act_lat, tbl[i].lat);
      chk($sformatf("vec%0d_rd", i), act_rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), act_err, tbl[i].err);
      chk($sformatf("vec%0d_led", i), act_led, tbl[i].led);
      chk($sformatf("vec%0d_we", i), act_we, tbl[i].we);
      if (tbl[i].we == 1) chk($sformatf("vec%0d_waddr", i), we_addr, tbl[i].a[11:2]);
    end

    // Counter load and wrap
    apply(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 16'h0);
    compare_model("cnt_wr");
    apply(1'b1, 1'b0, 32'hF000_0004, 32'h0, 16'h0);
    compare_model("cnt_rd1");
    chk("cnt_rd1_abs", act_rd, 32'hFFFF_FFFF);
    apply(1'b1, 1'b0, 32'hF000_0004, 32'h0, 16'h0);
    compare_model("cnt_rd2");
    chk("cnt_wrapped", (act_rd < 32'd8), 1'b1);

    // Held fetch request: one pulse every L+2 cycles
    @(negedge clk);
    bus.mem_r    = 1'b1;
    bus.mem_w    = 1'b0;
    bus.addr_bus = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("held_ready_%0d", k), bus.MIO_ready, (k % (L + 2) == L + 1));
      if (k == L + 1) chk("held_rd", bus.cpu_data4bus, ref_mem[0]);
    end
    bus.mem_r = 1'b0;
    m_rd = ref_mem[0];

    // Reset during the write's first RAM_WAIT cycle
    old = ref_mem[16];
    @(negedge clk);
    bus.mem_w        = 1'b1;
    bus.addr_bus     = 32'h0000_0040;
    bus.cpu_data2bus = ~old;
    @(posedge clk);
    @(negedge clk);
    bus.mem_w = 1'b0;
    chk("mid_we_before", ram_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_we", ram_we, 1'b0);
    chk("mid_addr", ram_addr, 10'h0);
    chk("mid_din", ram_din, 32'h0);
    chk("mid_ready", bus.MIO_ready, 1'b0);
    chk("mid_rd", bus.cpu_data4bus, 32'h0);
    chk("mid_led", led_out, 16'h0);
    chk("mid_err", bus.bus_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.MIO_ready) seen++;
    end
    chk("mid_no_ready", seen, 0);
    apply(1'b1, 1'b0, 32'h0000_0040, 32'h0, 16'h0);
    compare_model("mid_readback");
    chk("mid_old_data", act_rd, old);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, 9);
      op   = $urandom_range(0, 9);
      rd_v = $urandom;
      ra   = $urandom;
      if (sel < 6)       ra = {20'h0, ra[11:0]};
      else if (sel == 6) ra = 32'hF000_0000 | {30'h0, ra[1:0]};
      else if (sel == 7) ra = 32'hF000_0004 | {30'h0, ra[1:0]};
      else if (region(ra) != 3) ra = 32'h8000_0000 | {16'h0, ra[15:0]};
      apply(op == 9 || op < 5, op >= 5, ra, rd_v, 16'($urandom));
      compare_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus.md
Name: mio_bus

Overview:
- Memory/IO bus unit directly downstream of the multi-cycle CPU controller.
- Consumes the controller's MemRead/MemWrite strobes and the datapath address/store data.
- Decodes the address to block RAM or memory-mapped peripherals (LED register, switch input, free-running counter).
- Returns read data and produces the one-cycle MIO_ready completion pulse that releases the controller from instruction fetch.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM spans 0x0000_0000 .. 4*2^RAM_AW-1).
- RAM_LATENCY, 2, cycles from RAM address/strobe to valid ram_dout; legal range 1..7.
- IO_BASE, 32'hF000_0000, base of peripheral window.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mem_r  in  1  read request (controller MemRead).
- mem_w  in  1  write request (controller MemWrite).
- addr_bus  in  32  byte address from datapath (alu_reg/PC mux).
- cpu_data2bus  in  32  store data.
- cpu_data4bus  out  32  read data to IR/DR.
- MIO_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  sticky error flag.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data.
- sw_in  in  16  switch inputs.
- led_out  out  16  LED register.

Behaviour:
- Reset (async): FSM=IDLE, MIO_ready=0, cpu_data4bus=0, ram_we=0, ram_addr=0, ram_din=0, led_out=0, counter=0, bus_err=0, wait counter=0. Reset mid-transaction aborts it: no write commits and no ready pulse.
- Request sampling:
  - Sampled only in IDLE.
  - If mem_r|mem_w is high, addr_bus, cpu_data2bus and the request type are latched that cycle, so a one-cycle strobe suffices.
  - If both mem_r and mem_w are high: treat as write and set bus_err.
- Decode on latched address:
  - RAM if addr[31:RAM_AW+2]==0.
  - LED/SW if addr==IO_BASE.
  - Counter if addr==IO_BASE+4.
  - Everything else unmapped.
  - addr[1:0] is ignored (word access only).
- FSM states:
  - IDLE: wait for a request. RAM request -> RAM_WAIT. Peripheral or unmapped -> DONE.
  - RAM_WAIT:
    - ram_addr=latched addr[RAM_AW+1:2].
    - For a write, ram_we=1 for exactly the first RAM_WAIT cycle with ram_din=latched data.
    - Wait counter counts to RAM_LATENCY, then -> DONE. On that transition a read captures ram_dout into cpu_data4bus.
  - DONE:
    - MIO_ready=1 for exactly this cycle, then -> IDLE.
    - Peripheral reads load cpu_data4bus on entry to DONE: {16'h0,sw_in} for LED/SW, counter value for the counter.
    - Peripheral writes commit on entry to DONE: led_out<=data[15:0], or counter<=data.
    - Unmapped read returns 32'h0. Unmapped write is dropped. Either sets bus_err.
- Latency:
  - Peripheral/unmapped: request cycle N -> MIO_ready in cycle N+1.
  - RAM: MIO_ready in cycle N+1+RAM_LATENCY.
- cpu_data4bus holds the last read value until the next read completes. Writes do not disturb it.
- Request still high when back in IDLE after DONE starts a new transaction (level semantics). The controller drops MemRead after fetch.
- Counter:
  - 32-bit, increments every cycle, wraps 0xFFFF_FFFF->0.
  - A counter write loads the written value in that cycle, overriding the increment; increment resumes next cycle.
- bus_err is cleared only by reset.

Decomposition:
- Shared package mio_pkg holds:
  - state encoding (IDLE, RAM_WAIT, DONE);
  - IO_BASE and peripheral offsets (LED_SW_OFS=0, CNT_OFS=4);
  - region-decode enum (RAM, LED_SW, CNT, UNMAPPED).
- Natural sub-module: mio_decode, a combinational address -> region decoder reused by future DMA/debug ports.
- Counter and LED register stay inline.

Test Plan:
- Write then read RAM, RAM_LATENCY=2:
  - Stimulus: mem_w pulse, addr 0x10, data 0xDEADBEEF; then mem_r pulse, addr 0x10.
  - Required: ram_we high exactly one cycle with ram_addr=4; MIO_ready 3 cycles after each request; cpu_data4bus=0xDEADBEEF.
- LED/switch:
  - Stimulus: write 0x0001_A5A5 to 0xF000_0000; set sw_in=0x3C3C and read 0xF000_0000.
  - Required: led_out=0xA5A5; cpu_data4bus=0x0000_3C3C; MIO_ready one cycle after each request.
- Counter:
  - Stimulus: write 0xFFFF_FFFE to 0xF000_0004; read one cycle later.
  - Required: read returns wrap-consistent value (0xFFFF_FFFF or 0x0); counter wraps through 0.
- Unmapped and conflicting requests:
  - Stimulus: read 0x8000_0000; separately, mem_r=mem_w=1 to a RAM address.
  - Required: unmapped read returns 0, MIO_ready pulses, bus_err=1; the dual request performs the write and bus_err stays 1.
- Held fetch request:
  - Stimulus: mem_r held high for 10 cycles at addr 0x0.
  - Required: MIO_ready pulses every RAM_LATENCY+2 cycles, each pulse exactly one cycle wide.
- Reset mid-transaction:
  - Stimulus: assert reset during RAM_WAIT of a write.
  - Required: outputs are zero immediately (async); no later MIO_ready; a subsequent read of that address returns the old contents.
